// File: rtl/fcc_pkg.sv
// Shared read-beat definitions for the fcc read path: beat packing {last,id,user,data}.
package fcc_pkg;
  localparam int unsigned RDATA_W = 32;
  localparam int unsigned RUSER_W = 4;
  localparam int unsigned RID_W   = 16;
  localparam int unsigned RBEAT_W = 1 + RID_W + RUSER_W + RDATA_W;

  typedef struct packed {
    logic               last;
    logic [RID_W-1:0]   id;
    logic [RUSER_W-1:0] user;
    logic [RDATA_W-1:0] data;
  } rbeat_t;
endpackage

// File: rtl/fcc_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module fcc_sdp_ram #(
  parameter int unsigned WIDTH = 53,
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: neither the array nor the read register is reset, so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end
endmodule

// File: rtl/fcc_rpage_buf.sv
// Read-page buffer behind fcc_core channel 0: circular RAM FIFO, page credit toward the core,
// and a prefetching output register toward the host DMA.
module fcc_rpage_buf
  import fcc_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned DEPTH      = 4096,
  parameter  int unsigned PAGE_WORDS = 1152,
  localparam int unsigned AW         = $clog2(DEPTH),
  localparam int unsigned CW         = AW + 1
) (
  input  logic                  usr_clk,
  input  logic                  usr_rst,
  input  logic                  i_rvalid,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [3:0]            i_ruser,
  input  logic [15:0]           i_rid,
  input  logic                  i_rlast,
  output logic                  o_rpage_buf_ready,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic [3:0]            o_m_user,
  output logic [15:0]           o_m_id,
  output logic                  o_m_last,
  output logic [CW-1:0]         o_level,
  output logic                  o_ovf
);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] PAGE_C  = CW'(PAGE_WORDS);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, count_ram_q, count_ram_d, rcv_cnt_q, rcv_cnt_d;
  logic          in_page_q, in_page_d, ram_vld_q, ram_vld_d, out_vld_q, out_vld_d;
  logic          ovf_q, ovf_d, ready_q, ready_d;
  rbeat_t        out_q, out_d, wr_beat, rd_beat;

  logic          full, wr_en, pop, move, fetch;
  logic [CW-1:0] reserve;
  logic [CW:0]   committed;

  assign full    = (count_q == DEPTH_C);
  assign wr_en   = i_rvalid & ~full;
  assign pop     = out_vld_q & i_m_ready;
  // The RAM read register is a pipeline stage of its own; it advances into the output register
  // whenever that register is empty or being consumed.
  assign move    = ram_vld_q & (~out_vld_q | i_m_ready);
  assign fetch   = (count_ram_q != '0) & (~ram_vld_q | move);
  assign wr_beat = '{last: i_rlast, id: i_rid, user: i_ruser, data: i_rdata};

  assign reserve   = (in_page_q && (rcv_cnt_q < PAGE_C)) ? PAGE_C - rcv_cnt_q : '0;
  // free >= PAGE_WORDS rewritten as a sum so nothing can underflow.
  assign committed = {1'b0, count_q} + {1'b0, reserve} + (CW+1)'(PAGE_WORDS);

  fcc_sdp_ram #(.WIDTH(RBEAT_W), .DEPTH(DEPTH)) u_ram (
    .clk_i     (usr_clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_beat),
    .rd_en_i   (fetch),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_beat)
  );

  always_comb begin
    // NOTE: next-state logic uses blocking '='; only the clocked block below uses '<='.
    // NOTE: every _d is assigned unconditionally first, so no latch can be inferred.
    wr_ptr_d    = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = fetch ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(wr_en) - CW'(pop);
    count_ram_d = count_ram_q + CW'(wr_en) - CW'(fetch);
    in_page_d   = wr_en ? ~i_rlast : in_page_q;
    rcv_cnt_d   = rcv_cnt_q;
    if (wr_en) rcv_cnt_d = i_rlast ? '0 : rcv_cnt_q + CW'(1);
    ram_vld_d   = fetch | (ram_vld_q & ~move);
    out_vld_d   = move | (out_vld_q & ~i_m_ready);
    out_d       = move ? rd_beat : out_q;
    ovf_d       = ovf_q | (i_rvalid & full);
    ready_d     = (committed <= (CW+1)'(DEPTH));
  end

  always_ff @(posedge usr_clk or posedge usr_rst) begin
    if (usr_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      count_ram_q <= '0;
      rcv_cnt_q   <= '0;
      in_page_q   <= 1'b0;
      ram_vld_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      count_ram_q <= count_ram_d;
      rcv_cnt_q   <= rcv_cnt_d;
      in_page_q   <= in_page_d;
      ram_vld_q   <= ram_vld_d;
      out_vld_q   <= out_vld_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      ready_q     <= ready_d;
    end
  end

  assign o_rpage_buf_ready = ready_q;
  assign o_m_valid         = out_vld_q;
  assign o_m_data          = out_q.data;
  assign o_m_user          = out_q.user;
  assign o_m_id            = out_q.id;
  assign o_m_last          = out_q.last;
  assign o_level           = count_q;
  assign o_ovf             = ovf_q;
endmodule

// File: tb/tb_fcc_rpage_buf.sv
// Self-checking bench for fcc_rpage_buf: directed phases with random data/backpressure,
// checked against a queue-based model of the buffer, its page credit and overflow flag.
module tb_fcc_rpage_buf;
  import fcc_pkg::*;

  localparam int DEPTH = 4096;
  localparam int PAGE  = 1152;
  localparam int CW    = 13;

  logic          usr_clk;
  logic          usr_rst;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic [3:0]    i_ruser;
  logic [15:0]   i_rid;
  logic          i_rlast;
  logic          o_rpage_buf_ready;
  logic          o_m_valid;
  logic          i_m_ready;
  logic [31:0]   o_m_data;
  logic [3:0]    o_m_user;
  logic [15:0]   o_m_id;
  logic          o_m_last;
  logic [CW-1:0] o_level;
  logic          o_ovf;

  fcc_rpage_buf dut (
    .usr_clk           (usr_clk),
    .usr_rst           (usr_rst),
    .i_rvalid          (i_rvalid),
    .i_rdata           (i_rdata),
    .i_ruser           (i_ruser),
    .i_rid             (i_rid),
    .i_rlast           (i_rlast),
    .o_rpage_buf_ready (o_rpage_buf_ready),
    .o_m_valid         (o_m_valid),
    .i_m_ready         (i_m_ready),
    .o_m_data          (o_m_data),
    .o_m_user          (o_m_user),
    .o_m_id            (o_m_id),
    .o_m_last          (o_m_last),
    .o_level           (o_level),
    .o_ovf             (o_ovf)
  );

  initial usr_clk = 1'b0;
  always #5 usr_clk = ~usr_clk;

  int     n_cmp = 0;
  int     n_err = 0;
  rbeat_t exp_q[$];
  bit     m_in_page;
  int     m_rcv;
  bit     m_ovf;
  bit     exp_rdy;
  int     cyc;
  int     first_wr_cyc;
  int     first_val_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Credit the buffer should advertise for the model's current contents.
  function automatic bit model_ready();
    int res;
    res = (m_in_page && m_rcv < PAGE) ? PAGE - m_rcv : 0;
    return (DEPTH - exp_q.size() - res) >= PAGE;
  endfunction

  // One clock: sample handshakes before the edge, update the model, check after the edge.
  task automatic cycle();
    bit     acc, pop, hold_now;
    rbeat_t cur, in_b, now_b;
    acc      = i_rvalid && (exp_q.size() < DEPTH);
    pop      = o_m_valid && i_m_ready;
    hold_now = o_m_valid && !i_m_ready;
    cur      = '{o_m_last, o_m_id, o_m_user, o_m_data};
    in_b     = '{i_rlast, i_rid, i_ruser, i_rdata};
    if (i_rvalid && !acc) m_ovf = 1'b1;
    @(posedge usr_clk);
    #1;
    cyc++;
    if (pop) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL pop_empty: observed=beat %0h expected=no beat", cur);
      end
      if (exp_q.size() != 0) check("beat", 64'(cur), 64'(exp_q.pop_front()));
    end
    if (acc) begin
      exp_q.push_back(in_b);
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (i_rlast) begin
        m_in_page = 1'b0;
        m_rcv     = 0;
      end else begin
        m_in_page = 1'b1;
        m_rcv++;
      end
    end
    if (o_m_valid && first_val_cyc < 0) first_val_cyc = cyc;
    if (hold_now) begin
      now_b = '{o_m_last, o_m_id, o_m_user, o_m_data};
      check("hold_valid", 64'(o_m_valid), 64'd1);
      check("hold_beat", 64'(now_b), 64'(cur));
    end
    check("level", 64'(o_level), 64'(exp_q.size()));
    check("ovf", 64'(o_ovf), 64'(m_ovf));
    check("ready", 64'(o_rpage_buf_ready), 64'(exp_rdy));
    exp_rdy = model_ready();
  endtask

  // Send n beats; beat index base+k carries last when it ends a PAGE-sized page.
  task automatic send(input int n, input int base, input bit rnd, input bit rnd_rdy);
    for (int k = 0; k < n; k++) begin
      i_rvalid = 1'b1;
      i_rdata  = rnd ? $urandom : 32'(base + k);
      i_ruser  = rnd ? 4'($urandom) : 4'h0;
      i_rid    = rnd ? 16'($urandom) : 16'h00A5;
      i_rlast  = ((base + k) % PAGE) == (PAGE - 1);
      if (rnd_rdy) i_m_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    i_rvalid = 1'b0;
    i_rlast  = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget    = 20000;
    i_rvalid  = 1'b0;
    i_m_ready = 1'b1;
    while (exp_q.size() != 0 && budget > 0) begin
      cycle();
      budget--;
    end
    repeat (3) cycle();
    check("drain_valid", 64'(o_m_valid), 64'd0);
    check("drain_level", 64'(o_level), 64'd0);
  endtask

  // Assert reset away from a clock edge, check it took effect at once, then release.
  task automatic reset_check();
    usr_rst  = 1'b1;
    i_rvalid = 1'b0;
    i_rlast  = 1'b0;
    #1;
    check("rst_valid", 64'(o_m_valid), 64'd0);
    check("rst_data", 64'(o_m_data), 64'd0);
    check("rst_user", 64'(o_m_user), 64'd0);
    check("rst_id", 64'(o_m_id), 64'd0);
    check("rst_last", 64'(o_m_last), 64'd0);
    check("rst_level", 64'(o_level), 64'd0);
    check("rst_ovf", 64'(o_ovf), 64'd0);
    check("rst_ready", 64'(o_rpage_buf_ready), 64'd0);
    exp_q.delete();
    m_in_page     = 1'b0;
    m_rcv         = 0;
    m_ovf         = 1'b0;
    first_wr_cyc  = -1;
    first_val_cyc = -1;
    @(posedge usr_clk);
    #1;
    check("rst_ready_held", 64'(o_rpage_buf_ready), 64'd0);
    usr_rst = 1'b0;
    exp_rdy = model_ready();
  endtask

  initial begin
    usr_rst   = 1'b1;
    i_rvalid  = 1'b0;
    i_rdata   = '0;
    i_ruser   = '0;
    i_rid     = '0;
    i_rlast   = 1'b0;
    i_m_ready = 1'b0;
    cyc       = 0;

    reset_check();
    cycle();
    check("ready_after_release", 64'(o_rpage_buf_ready), 64'd1);

    // Single page, data = index, sink always ready.
    i_m_ready = 1'b1;
    send(PAGE, 0, 1'b0, 1'b0);
    drain();
    check("first_beat_latency", 64'(first_val_cyc - first_wr_cyc), 64'd2);

    // Credit: sink stalled while pages accumulate.
    i_m_ready = 1'b0;
    send(1, 0, 1'b1, 1'b0);
    cycle();
    check("credit_p1_first", 64'(o_rpage_buf_ready), 64'd1);
    send(PAGE - 1, 1, 1'b1, 1'b0);
    send(PAGE, 0, 1'b1, 1'b0);
    cycle();
    check("credit_p2_done", 64'(o_rpage_buf_ready), 64'd1);
    check("credit_p2_level", 64'(o_level), 64'd2304);
    send(1, 0, 1'b1, 1'b0);
    cycle();
    check("credit_p3_first", 64'(o_rpage_buf_ready), 64'd0);
    i_m_ready = 1'b1;
    repeat (1000) cycle();
    i_m_ready = 1'b0;
    cycle();
    check("credit_drained", 64'(o_rpage_buf_ready), 64'd1);
    check("credit_drained_level", 64'(o_level), 64'd1305);
    send(PAGE - 1, 1, 1'b1, 1'b0);
    drain();

    // Backpressure: random ready over two pages.
    send(2 * PAGE, 0, 1'b1, 1'b1);
    drain();

    // Pointer wrap: three buffers' worth at full rate.
    i_m_ready = 1'b1;
    send(3 * DEPTH, 0, 1'b1, 1'b0);
    drain();

    // Overflow: fill completely, then one more beat that must be dropped.
    i_m_ready = 1'b0;
    send(DEPTH, 0, 1'b1, 1'b0);
    check("full_level", 64'(o_level), 64'(DEPTH));
    check("full_no_ovf", 64'(o_ovf), 64'd0);
    send(1, DEPTH, 1'b1, 1'b0);
    check("ovf_set", 64'(o_ovf), 64'd1);
    check("ovf_level", 64'(o_level), 64'(DEPTH));
    drain();
    check("ovf_sticky", 64'(o_ovf), 64'd1);

    // Reset in the middle of a page, then a clean page.
    send(500, 0, 1'b1, 1'b1);
    reset_check();
    i_m_ready = 1'b1;
    send(PAGE, 0, 1'b0, 1'b0);
    drain();
    check("post_reset_latency", 64'(first_val_cyc - first_wr_cyc), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
